// File: rtl/uart_fifo_host.sv
// uart_fifo_host: UART transceiver with 16x oversampled RX and TX/RX FIFOs.
// Define UART_PARITY_EN to add one even-parity bit after the data bits.
module uart_fifo_host #(
    parameter int unsigned BAUD_DIV   = 326,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 16;
    localparam int unsigned BW = 4;
    localparam int unsigned SW = 5;
    localparam logic [CW-1:0] TICK_MAX = CW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] PH_BIT   = SW'(15);
    localparam logic [SW-1:0] PH_HALF  = SW'(7);
    localparam logic [SW-1:0] PH_STOP  = SW'(16 * STOP_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Free-running oversample tick
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
    end

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]        tx_wr_ptr, tx_rd_ptr;
    logic                 tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                      (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
        end
    end

    // TX framer; the shift register rotates so its XOR stays the data parity
    state_t               tx_state;
    logic [SW-1:0]        tx_phase;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;

    assign tx_pop  = tick && !tx_empty &&
                     ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_phase == PH_STOP));
    assign tx_busy = !tx_empty || (tx_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_phase <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_out   <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_phase <= '0;
            tx_shift <= tx_mem[tx_rd_ptr[AW-1:0]];
            tx_out   <= 1'b0;
        end else if (tick && tx_state != S_IDLE) begin
            tx_phase <= tx_phase + SW'(1);
            case (tx_state)
                S_START: if (tx_phase == PH_BIT) begin
                    tx_state <= S_DATA;
                    tx_phase <= '0;
                    tx_bit   <= '0;
                    tx_out   <= tx_shift[0];
                end
                S_DATA: if (tx_phase == PH_BIT) begin
                    tx_phase <= '0;
                    tx_shift <= {tx_shift[0], tx_shift[DATA_BITS-1:1]};
                    if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state <= S_PARITY;
                        tx_out   <= ^tx_shift;
`else
                        tx_state <= S_STOP;
                        tx_out   <= 1'b1;
`endif
                    end else begin
                        tx_bit <= tx_bit + BW'(1);
                        tx_out <= tx_shift[1];
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (tx_phase == PH_BIT) begin
                    tx_state <= S_STOP;
                    tx_phase <= '0;
                    tx_out   <= 1'b1;
                end
`endif
                S_STOP: if (tx_phase == PH_STOP) begin
                    tx_state <= S_IDLE;
                    tx_phase <= '0;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // RX input synchroniser
    logic rx_meta, rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]        rx_wr_ptr, rx_rd_ptr;
    logic                 rx_full, rx_push, rx_pop, rx_done, rx_good, rx_par_ok;
    logic [DATA_BITS-1:0] rx_shift;
    state_t               rx_state;
    logic [SW-1:0]        rx_phase;
    logic [BW-1:0]        rx_bit;

    assign rx_valid = (rx_wr_ptr != rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                      (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
    assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr[AW-1:0]] : '0;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_done  = tick && (rx_state == S_STOP) && (rx_phase == PH_BIT);
    assign rx_good  = rx_done && rx_s && rx_par_ok;
    assign rx_push  = rx_good && (!rx_full || rx_pop);

`ifdef UART_PARITY_EN
    logic rx_par;
    assign rx_par_ok = (rx_par == ^rx_shift);
`else
    assign rx_par_ok     = 1'b1;
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
        end
    end

    // RX deframer: start validated at half bit, then mid-bit samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= S_IDLE;
            rx_phase     <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (rx_state)
                S_IDLE: if (!rx_s) begin
                    rx_state <= S_START;
                    rx_phase <= '0;
                end
                S_START: if (tick) begin
                    rx_phase <= rx_phase + SW'(1);
                    if (rx_phase == PH_HALF) begin
                        rx_phase <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    rx_phase <= rx_phase + SW'(1);
                    if (rx_phase == PH_BIT) begin
                        rx_phase <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + BW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (tick) begin
                    rx_phase <= rx_phase + SW'(1);
                    if (rx_phase == PH_BIT) begin
                        rx_phase <= '0;
                        rx_par   <= rx_s;
                        rx_state <= S_STOP;
                    end
                end
`endif
                S_STOP: if (tick) begin
                    rx_phase <= rx_phase + SW'(1);
                    if (rx_phase == PH_BIT) begin
                        rx_phase     <= '0;
                        rx_state     <= S_IDLE;
                        rx_frame_err <= !rx_s;
                        rx_overrun   <= rx_good && rx_full && !rx_pop;
`ifdef UART_PARITY_EN
                        rx_parity_err <= rx_s && !rx_par_ok;
`endif
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_fifo_host.md
# uart_fifo_host

Parametrised UART transceiver that succeeds the fixed 8-bit, single-register UART host. It adds 16x oversampled reception, configurable data width and stop bits, TX and RX FIFOs with valid/ready handshakes, and framing, overrun and optional parity error reporting. It sits between a byte-stream client and the serial pins, and serves as a host circuit for the generation flow.

## Interface
- `BAUD_DIV`, 326: clk cycles per oversample tick; bit time = 16 ticks (50 MHz / 9600 baud). Legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits sent, 1 or 2; RX checks only the first stop bit.
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  DATA_BITS  byte to transmit.
- `tx_valid`  in  1  push request into TX FIFO.
- `tx_ready`  out  1  TX FIFO not full.
- `tx_out`  out  1  serial output, idle high.
- `tx_busy`  out  1  TX FIFO non-empty or frame in progress.
- `rx_in`  in  1  serial input, asynchronous.
- `rx_data`  out  DATA_BITS  RX FIFO head (show-ahead).
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_ready`  in  1  consumer pop; pop occurs when `rx_valid && rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: good frame dropped, RX FIFO full.
- `rx_parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without macro).

## Operation
- **Tick counter:** free-running 0..BAUD_DIV-1. `tick` is asserted for one cycle when the count equals BAUD_DIV-1.
- **TX FIFO:**
  - Push when `tx_valid && tx_ready`.
  - Pop by the TX FSM on frame start.
- **TX FSM, IDLE→START→DATA→(PARITY)→STOP→IDLE:**
  - Each state lasts 16 ticks; STOP lasts 16·STOP_BITS ticks.
  - IDLE leaves on the first `tick` with the FIFO non-empty. It pops the head into the shift register.
  - Data is sent LSB first.
  - After STOP, a non-empty FIFO starts the next frame at the following `tick`, with no idle gap beyond one tick.
- **RX path:**
  - Two-flop synchroniser on `rx_in` (reset value 1).
  - IDLE: the synchronised input low moves the FSM to START and clears the tick-phase counter.
  - START: after 8 ticks, re-sample. If high, it was a glitch: return to IDLE with no pulse. If low, go to DATA.
  - DATA: sample every 16 ticks (bit midpoint), shifting in LSB first.
  - PARITY (macro only): sample 16 ticks later.
  - STOP: sample 16 ticks later, then return to IDLE the same cycle.
- **Frame results:**
  - Stop low: pulse `rx_frame_err`; the word is discarded.
  - Parity mismatch (macro only): pulse `rx_parity_err`; the word is discarded.
  - Otherwise push the word. If the FIFO is full and no pop occurs that cycle, pulse `rx_overrun` and drop the word.
- **FIFO boundaries:**
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full = MSBs differ and the rest are equal.
  - A simultaneous push and pop on a full RX FIFO succeeds and the count is unchanged.
  - A pop on an empty FIFO is ignored.

## Timing
- **Reset values:**
  - `tx_out`=1, `tx_busy`=0, `tx_ready`=1.
  - `rx_valid`=0, `rx_data`=0.
  - All error pulses 0.
  - FIFOs empty, both FSMs in IDLE, tick counter 0.
- **Reset mid-frame:** `tx_out` returns to 1 asynchronously. The partial RX word is lost and no pulse is generated.
- **TX latency:** the push edge to `tx_out` falling takes 1..BAUD_DIV+1 cycles when idle.
- **RX latency:** the stop-sample tick to `rx_valid` high is 1 cycle, including the push.
- **Outputs:** `tx_ready` and `rx_valid` are registered-flag derived and change the cycle after the push or pop edge.
- **Frame length:** 16·(1+DATA_BITS+P+STOP_BITS) ticks, where P = 1 with the macro and 0 without.

## Configuration
- **Macro:** `UART_PARITY_EN`.
- **Defined:** one even-parity bit (XOR of the data bits) is sent after DATA. RX checks it and drives `rx_parity_err`.
- **Undefined:** no parity bit in either direction, and `rx_parity_err` is constant 0.

## Test plan
All scenarios use the bench settings BAUD_DIV=4, DATA_BITS=8, STOP_BITS=1.
- **Loopback:** tie `tx_out`→`rx_in`, push 0xA5 → `tx_out` shows 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles. `rx_data`=0xA5 with `rx_valid`=1, and no error pulses.
- **TX back-pressure:** push 9 words with FIFO_DEPTH=8 while no frame has started → `tx_ready`=0 after 8 stored. The 9th word is not accepted. All 8 words are sent in order, back to back.
- **Framing error:** drive a frame with data 0x3C and stop bit 0 → one `rx_frame_err` pulse, `rx_valid` stays 0.
- **Overrun:** send 9 frames with `rx_ready`=0 → `rx_overrun` pulses once, on frame 9. Popping 8 times returns frames 1..8.
- **Glitch rejection:** a 2-cycle low pulse on `rx_in` → no pulse and no data; the FSM is back in IDLE within 8 ticks.
- **Parity (macro only):** a frame with data 0x07 and parity bit 0 → `rx_parity_err` pulse. Parity bit 1 → 0x07 accepted.
